// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the Execute stage: shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up applied on completion.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPUTING = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             busy_c, latch_c, step_c, finish_c;
    logic [CW-1:0]    count;
    logic             is_div, neg_q, neg_r;
    logic [WIDTH-1:0] opnd_a;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] orig_a;   // dividend as latched, for divide-by-zero
    logic [AW-1:0]    acc;      // product, or quotient in the low word
    logic [WIDTH-1:0] rem;

    // Operand magnitudes; unsigned ops (MCycleOp[0]=1) never negate
    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    assign sign1 = ~MCycleOp[0] & Operand1[WIDTH-1];
    assign sign2 = ~MCycleOp[0] & Operand2[WIDTH-1];
    assign mag1  = sign1 ? WIDTH'(-Operand1) : Operand1;
    assign mag2  = sign2 ? WIDTH'(-Operand2) : Operand2;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        latch_c   = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    busy_c    = 1'b1;
                    latch_c   = 1'b1;
                    state_nxt = COMPUTING;
                end
            end
            COMPUTING: begin
                busy_c = 1'b1;
                step_c = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    finish_c  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = busy_c & ~RESET;

    // One shift-add multiply step
    logic [WIDTH:0]  mul_sum;
    logic [AW-1:0]   acc_mul;
    assign mul_sum = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd_a} : {(WIDTH+1){1'b0}});
    assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

    // One restoring divide step on the WIDTH+1-bit partial remainder
    logic [WIDTH:0]   part_rem, div_diff;
    logic             div_borrow;
    logic [WIDTH-1:0] rem_div;
    logic [AW-1:0]    acc_div;
    assign part_rem                 = {rem, acc[WIDTH-1]};
    assign {div_borrow, div_diff}   = {1'b0, part_rem} - {2'b00, opnd_a};
    assign rem_div = div_borrow ? part_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign acc_div = {acc[AW-1:WIDTH], acc[WIDTH-2:0], ~div_borrow};

    // Both top bits are zero whenever the remainder stays below the divisor
    logic unused_top;
    assign unused_top = part_rem[WIDTH] ^ div_diff[WIDTH];

    // Final results from the last iteration, sign-corrected
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] res1_c, res2_c;
    always_comb begin
        prod_fix = neg_q ? AW'(-acc_mul) : acc_mul;
        res1_c   = prod_fix[WIDTH-1:0];
        res2_c   = prod_fix[AW-1:WIDTH];
        if (is_div) begin
            if (opnd_a == '0) begin
                res1_c = '1;
                res2_c = orig_a;
            end else begin
                res1_c = neg_q ? WIDTH'(-acc_div[WIDTH-1:0]) : acc_div[WIDTH-1:0];
                res2_c = neg_r ? WIDTH'(-rem_div) : rem_div;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            opnd_a  <= '0;
            orig_a  <= '0;
            acc     <= '0;
            rem     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            if (latch_c) begin
                count  <= '0;
                is_div <= MCycleOp[1];
                neg_q  <= sign1 ^ sign2;
                neg_r  <= sign1;
                opnd_a <= MCycleOp[1] ? mag2 : mag1;
                orig_a <= Operand1;
                acc    <= {{WIDTH{1'b0}}, (MCycleOp[1] ? mag1 : mag2)};
                rem    <= '0;
            end else if (step_c) begin
                count <= count + CW'(1);
                acc   <= is_div ? acc_div : acc_mul;
                rem   <= is_div ? rem_div : rem;
            end
            if (finish_c) begin
                Result1 <= res1_c;
                Result2 <= res2_c;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed corner cases plus random
// operations against a plain-arithmetic 64-bit reference model.
module tb_mcycle_unit;
    localparam int unsigned W = 32;

    logic         CLK;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] last_r1, last_r2;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full-precision signed/unsigned arithmetic
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r1 = '0;
        r2 = '0;
        case (op)
            2'b00: begin sp = sa * sb; v = 64'(sp); r1 = v[31:0]; r2 = v[63:32]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; v = up; r1 = v[31:0]; r2 = v[63:32]; end
            default: begin
                if (b == '0) begin
                    r1 = '1;
                    r2 = a;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    v = 64'(sq); r1 = v[31:0];
                    v = 64'(sr); r2 = v[31:0];
                end else begin
                    r1 = a / b;
                    r2 = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op; Busy must hold for WIDTH+1 cycles, then results in DONE
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit perturb);
        logic [W-1:0] e1, e2;
        int bad;
        model(op, a, b, e1, e2);
        bad = 0;
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(negedge CLK);
        if (Busy !== 1'b1) bad++;
        for (int c = 1; c <= int'(W); c++) begin
            @(posedge CLK); #1;
            if (!hold) Start = 1'b0;
            if (perturb) begin
                Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
            end
            @(negedge CLK);
            if (Busy !== 1'b1) bad++;
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("busy_window", W'(bad), '0);
        chk("busy_done", W'(Busy), '0);
        chk("result1", Result1, e1);
        chk("result2", Result2, e2);
        last_r1 = e1;
        last_r2 = e2;
    endtask

    // IDLE with Start low: no stall, results held
    task automatic idle_check();
        @(posedge CLK); #1;
        Start = 1'b0;
        @(negedge CLK);
        chk("busy_idle", W'(Busy), '0);
        chk("hold_r1", Result1, last_r1);
        chk("hold_r2", Result2, last_r2);
    endtask

    initial begin
        logic [W-1:0] corner [8];
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_0002;
        corner[6] = 32'hFFFF_FFFE; corner[7] = 32'h1234_5678;

        RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        last_r1 = '0; last_r2 = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_busy", W'(Busy), '0);
        chk("reset_r1", Result1, '0);
        chk("reset_r2", Result2, '0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_check();
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        run_op(2'b11, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        idle_check();

        // Start held through DONE, then a new op issued in the following IDLE
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 1'b1);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b1);
        idle_check();

        // Reset in cycle 10 of a multiply
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'hCAFE_F00D; Operand2 = 32'h0000_0FFF;
        repeat (9) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("busy_in_reset", W'(Busy), '0);
        @(posedge CLK); #1;
        RESET = 1'b0; Start = 1'b0;
        @(negedge CLK);
        chk("abort_busy", W'(Busy), '0);
        chk("abort_r1", Result1, '0);
        chk("abort_r2", Result2, '0);
        run_op(2'b01, 32'hCAFE_F00D, 32'h0000_0FFF, 1'b0, 1'b0);

        for (int i = 0; i < 48; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_check();
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
